// File: rtl/enc_pkg.sv
// Shared types and encoding constants for the instruction encoder:
// mnemonic enum, MIPS-style opcode/funct fields and the load-session FSM state.
package enc_pkg;

  typedef enum logic [3:0] {
    MN_ADD = 4'd0,
    MN_SUB = 4'd1,
    MN_AND = 4'd2,
    MN_OR  = 4'd3,
    MN_XOR = 4'd4,
    MN_SLT = 4'd5,
    MN_SLL = 4'd6,
    MN_SRL = 4'd7,
    MN_LW  = 4'd8,
    MN_SW  = 4'd9,
    MN_BEQ = 4'd10,
    MN_J   = 4'd11
  } mnem_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_XOR = 6'b100110;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_SLL = 6'b000000;
  localparam logic [5:0] FUNCT_SRL = 6'b000010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [31:0] rtype_word(input logic [4:0] rs, input logic [4:0] rt,
                                             input logic [4:0] rd, input logic [4:0] shamt,
                                             input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

endpackage

// File: rtl/inst_fmt.sv
// Combinational instruction packer: mnemonic plus fields -> 32-bit machine word.
// Illegal mnemonics (12-15) pack to zero and raise the illegal flag.
module inst_fmt
  import enc_pkg::*;
(
  input  logic [3:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = 32'h0000_0000;
    illegal = 1'b0;
    case (mnem_e'(mnem))
      MN_ADD: word = rtype_word(rs, rt, rd, 5'd0, FUNCT_ADD);
      MN_SUB: word = rtype_word(rs, rt, rd, 5'd0, FUNCT_SUB);
      MN_AND: word = rtype_word(rs, rt, rd, 5'd0, FUNCT_AND);
      MN_OR:  word = rtype_word(rs, rt, rd, 5'd0, FUNCT_OR);
      MN_XOR: word = rtype_word(rs, rt, rd, 5'd0, FUNCT_XOR);
      MN_SLT: word = rtype_word(rs, rt, rd, 5'd0, FUNCT_SLT);
      // Shifts take their amount from shamt, so rs is forced to zero
      MN_SLL: word = rtype_word(5'd0, rt, rd, shamt, FUNCT_SLL);
      MN_SRL: word = rtype_word(5'd0, rt, rd, shamt, FUNCT_SRL);
      MN_LW:  word = {OP_LW, rs, rt, imm};
      MN_SW:  word = {OP_SW, rs, rt, imm};
      MN_BEQ: word = {OP_BEQ, rs, rt, imm};
      MN_J:   word = {OP_J, target};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Instruction loader: encodes accepted beats and writes them to instruction memory.
// Optional ENC_CHECK_EN drops illegal mnemonics instead of writing zero words.
module inst_encoder
  import enc_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        mnem,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic              last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

`ifdef ENC_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  state_e            state, state_nxt;
  logic              accept, start_acc, write, full_hit, term;
  logic [31:0]       word_p0;
  logic              illegal_p0;
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [31:0]       wdata_p1;
  logic [ADDR_W:0]   cnt;
  logic              err_q;

  inst_fmt u_fmt (
    .mnem    (mnem),
    .rs      (rs),
    .rt      (rt),
    .rd      (rd),
    .shamt   (shamt),
    .imm     (imm),
    .target  (target),
    .word    (word_p0),
    .illegal (illegal_p0)
  );

  assign accept    = in_valid && (state == ST_LOAD);
  assign start_acc = start && (state == ST_IDLE);
  assign write     = accept && !(CHECK_EN && illegal_p0);
  assign full_hit  = write && (cnt[ADDR_W-1:0] == {ADDR_W{1'b1}});
  assign term      = accept && (last || full_hit);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_acc) state_nxt = ST_LOAD;
      ST_LOAD: if (term) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_LOAD: begin in_ready = 1'b1; busy = 1'b1; end
      ST_DONE: begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // p0 -> p1: register the encoded word with its address
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= 32'h0000_0000;
      cnt      <= '0;
      err_q    <= 1'b0;
    end else begin
      vld_p1 <= write;
      if (write) begin
        addr_p1  <= cnt[ADDR_W-1:0];
        wdata_p1 <= word_p0;
      end
      if (start_acc)  cnt <= '0;
      else if (write) cnt <= cnt + (ADDR_W+1)'(1);
      if (start_acc)
        err_q <= 1'b0;
      else if ((full_hit && !last) || (accept && illegal_p0 && CHECK_EN))
        err_q <= 1'b1;
    end
  end

  assign imem_we    = vld_p1;
  assign imem_addr  = addr_p1;
  assign imem_wdata = wdata_p1;
  assign err        = err_q;
  assign count      = cnt;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: one default-width instance plus an ADDR_W=2
// instance for memory-full sessions; both share the same stimulus.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, last;
  logic [3:0]  mnem;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;

  logic        a_ready, a_we, a_busy, a_done, a_err;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic [8:0]  a_count;

  logic        b_ready, b_we, b_busy, b_done, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [2:0]  b_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(a_ready),
    .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .target(target),
    .last(last), .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
    .busy(a_busy), .done(a_done), .err(a_err), .count(a_count)
  );

  inst_encoder #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(b_ready),
    .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .target(target),
    .last(last), .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
    .busy(b_busy), .done(b_done), .err(b_err), .count(b_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] m, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [4:0] sh, input logic [15:0] im,
                      input logic [25:0] tg, input logic l);
    mnem = m; rs = s; rt = t; rd = d; shamt = sh; imm = im; target = tg; last = l;
    in_valid = 1'b1;
  endtask

  task automatic open_session();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; last = 1'b0;
    mnem = '0; rs = '0; rt = '0; rd = '0; shamt = '0; imm = '0; target = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_we", a_we, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_err", a_err, 0);
    chk("rst_count", a_count, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_wdata", a_wdata, 0);
    chk("rst_ready", a_ready, 0);

    // Single add beat
    open_session();
    chk("t1_ready", a_ready, 1);
    chk("t1_busy", a_busy, 1);
    beat(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("t1_we", a_we, 1);
    chk("t1_addr", a_addr, 0);
    chk("t1_wdata", a_wdata, 32'h0022_1820);
    chk("t1_done", a_done, 1);
    chk("t1_count", a_count, 1);
    tick();
    chk("t1_done_end", a_done, 0);
    chk("t1_we_end", a_we, 0);
    chk("t1_busy_end", a_busy, 0);

    // Back-to-back lw / beq / j, with start held during the session
    open_session();
    chk("t2_count_clr", a_count, 0);
    beat(4'd8, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b0);
    tick();
    chk("t2_we0", a_we, 1);
    chk("t2_addr0", a_addr, 0);
    chk("t2_wdata0", a_wdata, 32'h8C08_0004);
    start = 1'b1;
    beat(4'd10, 5'd8, 5'd9, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b0);
    tick();
    start = 1'b0;
    chk("t2_we1", a_we, 1);
    chk("t2_addr1", a_addr, 1);
    chk("t2_wdata1", a_wdata, 32'h1109_FFFF);
    chk("t2_ready1", a_ready, 1);
    beat(4'd11, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0010, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("t2_we2", a_we, 1);
    chk("t2_addr2", a_addr, 2);
    chk("t2_wdata2", a_wdata, 32'h0800_0010);
    chk("t2_count", a_count, 3);
    chk("t2_done", a_done, 1);
    tick();

    // sll with rs driven nonzero
    open_session();
    beat(4'd6, 5'd7, 5'd5, 5'd4, 5'd2, 16'h0, 26'h0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("t3_we", a_we, 1);
    chk("t3_wdata", a_wdata, 32'h0005_2080);
    tick();

    // Memory full on the ADDR_W=2 instance
    open_session();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_ready%0d", i), b_ready, (i < 4) ? 1 : 0);
      beat(4'd0, 5'd1, 5'd2, 5'(i), 5'd0, 16'h0, 26'h0, 1'b0);
      tick();
      chk($sformatf("t4_we%0d", i), b_we, (i < 4) ? 1 : 0);
      if (i < 4) begin
        chk($sformatf("t4_addr%0d", i), b_addr, i);
        chk($sformatf("t4_wdata%0d", i), b_wdata, 32'h0022_0020 | (i << 11));
      end
      if (i == 3) begin
        chk("t4_done", b_done, 1);
        chk("t4_err", b_err, 1);
      end
    end
    in_valid = 1'b0;
    chk("t4_count", b_count, 4);
    chk("t4_err_sticky", b_err, 1);
    chk("t4_idle", b_busy, 0);
    open_session();
    chk("t4_err_clr", b_err, 0);
    chk("t4_count_clr", b_count, 0);

    rst = 1'b1; tick(); rst = 1'b0;

    // Illegal mnemonics
    open_session();
    beat(4'd13, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    tick();
`ifdef ENC_CHECK_EN
    chk("t5_we", a_we, 0);
    chk("t5_err", a_err, 1);
    chk("t5_count", a_count, 0);
`else
    chk("t5_we", a_we, 1);
    chk("t5_wdata", a_wdata, 0);
    chk("t5_err", a_err, 0);
    chk("t5_count", a_count, 1);
`endif
    beat(4'd15, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("t5_done", a_done, 1);
`ifdef ENC_CHECK_EN
    chk("t5_we_last", a_we, 0);
    chk("t5_count_last", a_count, 0);
`else
    chk("t5_we_last", a_we, 1);
    chk("t5_addr_last", a_addr, 1);
    chk("t5_count_last", a_count, 2);
`endif
    tick();

    // Reset on the accepting cycle
    open_session();
    beat(4'd1, 5'd3, 5'd4, 5'd5, 5'd0, 16'h0, 26'h0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("t6_we", a_we, 0);
    chk("t6_busy", a_busy, 0);
    chk("t6_count", a_count, 0);
    chk("t6_ready", a_ready, 0);
    tick();
    chk("t6_we_next", a_we, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
